// File: rtl/mult_arb_pkg.sv
// mult_share_arb shared types: FSM state encoding and index width helper.
package mult_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or
// after the pointer, searching upward with wrap.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_ptr,
  output logic            o_found,
  output logic [OW-1:0]   o_idx
);

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % NREQ;
      if (i_req[j]) begin
        o_found = 1'b1;
        o_idx   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one shift-add multiplier among NREQ
// requesters. Define MULT_ARB_TIMEOUT_EN for the watchdog and err port.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [2*WIDTH-1:0]    result,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_finish,
  input  logic [2*WIDTH-1:0]    mul_o
`ifdef MULT_ARB_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  localparam int OW = idx_w(NREQ);

  state_t               r_state;
  state_t               w_next;
  logic [OW-1:0]        r_ptr;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        w_idx;
  logic                 w_found;
  logic                 w_tmo;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      r_done;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_busy;
  logic                 r_start;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_tmo;
  logic          r_err;

  assign w_tmo = (r_cnt + CW'(1)) == CW'(TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT && !mul_finish && !w_tmo)
        r_cnt <= r_cnt + CW'(1);
      if (r_state == WAIT && !mul_finish && w_tmo)
        r_tmo <= 1'b1;
      if (r_state == RESP) begin
        r_err <= r_tmo;
        r_tmo <= 1'b0;
      end
    end
  end

  assign err = r_err;
`else
  // Watchdog compiled out: WAIT only leaves on mul_finish.
  assign w_tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (mul_finish || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_gnt   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_busy  <= (w_next != IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= a_in[int'(w_idx)*WIDTH +: WIDTH];
            r_b     <= b_in[int'(w_idx)*WIDTH +: WIDTH];
            r_owner <= w_idx;
          end
        end
        ISSUE: begin
          r_gnt[r_owner] <= 1'b1;
          r_start        <= 1'b1;
        end
        WAIT: begin
          if (mul_finish)
            r_result <= mul_o;
          else if (w_tmo)
            r_result <= '0;
        end
        RESP: begin
          r_done[r_owner] <= 1'b1;
          if (int'(r_owner) == NREQ - 1)
            r_ptr <= '0;
          else
            r_ptr <= r_owner + OW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign result    = r_result;
  assign busy      = r_busy;
  assign mul_start = r_start;
  assign mul_a     = r_a;
  assign mul_b     = r_b;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb with a behavioural engine and
// a round-robin reference model.
module tb_mult_share_arb;
  localparam int N = 4;
  localparam int W = 4;
  localparam int T = 63;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   gnt, done;
  logic [2*W-1:0] result;
  logic           busy, mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_finish;
  logic [2*W-1:0] mul_o;
`ifdef MULT_ARB_TIMEOUT_EN
  logic           err;
`endif

  mult_share_arb #(.NREQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_o(mul_o)
`ifdef MULT_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int m_ptr = 0;

  // behavioural engine: finish pulse lat cycles after it sees start
  logic           eng_fin;
  logic           spur_fin = 1'b0;
  logic [2*W-1:0] eng_o;
  logic [2*W-1:0] spur_o = 8'h5A;
  logic [W-1:0]   eng_a, eng_b;
  int             eng_cnt;
  int             eng_lat = 1;
  bit             eng_hang = 1'b0;
  int             stab_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt <= 0;
      eng_fin <= 1'b0;
      eng_o   <= '0;
    end else begin
      eng_fin <= 1'b0;
      if (mul_start) begin
        eng_cnt <= eng_lat;
        eng_a   <= mul_a;
        eng_b   <= mul_b;
      end else if (eng_cnt > 0) begin
        if (mul_a !== eng_a || mul_b !== eng_b) stab_err <= stab_err + 1;
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1 && !eng_hang) begin
          eng_fin <= 1'b1;
          eng_o   <= 8'(eng_a) * 8'(eng_b);
        end
      end
    end
  end

  assign mul_finish = eng_fin | spur_fin;
  assign mul_o      = eng_fin ? eng_o : spur_o;

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  task automatic wait_gnt(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        idx = oh_idx(gnt);
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output int idx,
                           output int cyc, output int nst);
    idx = -1;
    cyc = 0;
    nst = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (mul_start) nst++;
      if (done != '0) begin
        idx = oh_idx(done);
        break;
      end
    end
  endtask

  task automatic txn(input logic [N-1:0] mask, input int lat,
                     input bit hold, output int g);
    int w, gc, d, dc, ns;
    logic [W-1:0] ea, eb;
    logic [2*W-1:0] ep;
    eng_lat = lat;
    req = mask;
    w = pick(mask, m_ptr);
    ea = a_in[w*W +: W];
    eb = b_in[w*W +: W];
    ep = 8'(ea) * 8'(eb);
    wait_gnt(g, gc);
    n_chk++;
    if (g !== w) $display("FAIL gnt_idx: got %0d want %0d", g, w);
    else n_pass++;
    n_chk++;
    if (gc !== 2) $display("FAIL gnt_lat: got %0d want 2", gc);
    else n_pass++;
    n_chk++;
    if (mul_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL start_busy: got %b%b want 11", mul_start, busy);
    else n_pass++;
    n_chk++;
    if (mul_a !== ea || mul_b !== eb)
      $display("FAIL operands: got %0d,%0d want %0d,%0d", mul_a, mul_b, ea, eb);
    else n_pass++;
    if (!hold) req = '0;
    wait_done(200, d, dc, ns);
    n_chk++;
    if (d !== w) $display("FAIL done_idx: got %0d want %0d", d, w);
    else n_pass++;
    n_chk++;
    if (dc !== lat + 3) $display("FAIL done_lat: got %0d want %0d", dc, lat + 3);
    else n_pass++;
    n_chk++;
    if (result !== ep) $display("FAIL result: got %0d want %0d", result, ep);
    else n_pass++;
    n_chk++;
    if (ns !== 0) $display("FAIL extra_start: got %0d want 0", ns);
    else n_pass++;
    m_ptr = (w + 1) % N;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({gnt, done, result} !== '0)
      $display("FAIL rst_gdr: got %h want 0", {gnt, done, result});
    else n_pass++;
    n_chk++;
    if ({busy, mul_start, mul_a, mul_b} !== '0)
      $display("FAIL rst_mul: got %h want 0", {busy, mul_start, mul_a, mul_b});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int g;
    a_in = '0;
    b_in = '0;
    a_in[3:0] = 4'd3;
    b_in[3:0] = 4'd5;
    txn(4'b0001, 9, 1'b0, g);
    n_chk++;
    if (result !== 8'd15) $display("FAIL single_res: got %0d want 15", result);
    else n_pass++;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    txn(4'b0011, 2, 1'b0, g);
    n_chk++;
    if (g !== 1) $display("FAIL ptr_after: got %0d want 1", g);
    else n_pass++;
  endtask

  task automatic test_fair();
    int g;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'(i + 1);
      b_in[i*W +: W] = W'(i + 2);
    end
    for (int t = 0; t < 5; t++) begin
      txn(4'hF, 3, 1'b1, g);
      n_chk++;
      if (g !== order[t]) $display("FAIL fair_%0d: got %0d want %0d", t, g, order[t]);
      else n_pass++;
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_max();
    int g;
    a_in[2*W +: W] = 4'hF;
    b_in[2*W +: W] = 4'hF;
    txn(4'b0100, 5, 1'b0, g);
    n_chk++;
    if (result !== 8'hE1) $display("FAIL max_res: got %h want e1", result);
    else n_pass++;
    n_chk++;
    if (stab_err !== 0) $display("FAIL stable: got %0d want 0", stab_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g, gc, nd;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    eng_lat = 20;
    req = 4'b0010;
    wait_gnt(g, gc);
    req = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({gnt, done, result, busy, mul_start, mul_a, mul_b} !== '0)
      $display("FAIL mid_rst: got %h want 0",
               {gnt, done, result, busy, mul_start, mul_a, mul_b});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done != '0) nd++;
    end
    n_chk++;
    if (nd !== 0) $display("FAIL mid_nodone: got %0d want 0", nd);
    else n_pass++;
    txn(4'hF, 2, 1'b0, g);
    n_chk++;
    if (g !== 0) $display("FAIL mid_first: got %0d want 0", g);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int g, bad;
    logic [2*W-1:0] r0;
    r0 = result;
    spur_o = 8'hAA;
    spur_fin = 1'b1;
    @(negedge clk);
    spur_fin = 1'b0;
    spur_o = 8'h5A;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != '0 || busy || result !== r0) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL spurious: got %0d want 0", bad);
    else n_pass++;
    a_in[3*W +: W] = W'($urandom);
    b_in[3*W +: W] = W'($urandom);
    txn(4'b1000, 4, 1'b0, g);
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 25; t++) begin
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      txn(N'($urandom_range(1, 15)), $urandom_range(1, 6), 1'b0, g);
    end
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g, gc, d, dc, ns, w;
    eng_hang = 1'b1;
    req = 4'b0010;
    w = pick(req, m_ptr);
    wait_gnt(g, gc);
    req = '0;
    wait_done(200, d, dc, ns);
    n_chk++;
    if (d !== w || dc !== T + 1)
      $display("FAIL tmo_done: got %0d@%0d want %0d@%0d", d, dc, w, T + 1);
    else n_pass++;
    n_chk++;
    if (err !== 1'b1 || result !== '0)
      $display("FAIL tmo_err: got %b,%0d want 1,0", err, result);
    else n_pass++;
    m_ptr = (w + 1) % N;
    eng_hang = 1'b0;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0) $display("FAIL tmo_pulse: got %b want 0", err);
    else n_pass++;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    txn(4'hF, 2, 1'b0, g);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fair();
    test_max();
    test_reset_mid();
    test_spurious();
    test_random();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
